// File: rtl/bus_pkg.sv
// Shared encodings for the L2 bus responder: op codes, snoop results and FSM states.
package bus_pkg;

  typedef enum logic [1:0] {
    OpRead  = 2'd0,
    OpWrite = 2'd1,
    OpRwim  = 2'd2,
    OpInval = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    SnpNohit = 2'd0,
    SnpHit   = 2'd1,
    SnpHitm  = 2'd2,
    SnpRsvd  = 2'd3
  } snp_e;

  typedef enum logic [2:0] {
    StIdle,
    StSnoop,
    StWaitWb,
    StMem,
    StResp
  } state_e;

  // The reserved result code is folded into HITM so a dirty owner is never missed.
  function automatic snp_e norm_snoop(input logic [1:0] r);
    return (r == 2'd3) ? SnpHitm : snp_e'(r);
  endfunction

endpackage

// File: rtl/bus_stat_counter.sv
// Saturating transaction counter; sticks at all-ones once full.
module bus_stat_counter #(
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [STAT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + STAT_W'(1);
    end
  end

endmodule

// File: rtl/l2_bus_target.sv
// Memory-side bus responder: snoop broadcast, HITM writeback wait, memory latency,
// completion with aggregated snoop result, plus per-op statistics.
module l2_bus_target
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned OFFSET_W      = 6,
  parameter int unsigned MEM_LAT       = 4,
  parameter int unsigned SNOOP_TIMEOUT = 8,
  parameter int unsigned STAT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              snp_valid,
  output logic [1:0]        snp_op,
  output logic [ADDR_W-1:0] snp_addr,
  input  logic              snp_result_valid,
  input  logic [1:0]        snp_result,
  input  logic              wb_valid,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_snoop,
  output logic [STAT_W-1:0] cnt_read,
  output logic [STAT_W-1:0] cnt_write,
  output logic [STAT_W-1:0] cnt_rwim,
  output logic [STAT_W-1:0] cnt_inval
);

  localparam int unsigned TO_W  = $clog2(SNOOP_TIMEOUT + 1);
  localparam int unsigned LAT_W = $clog2(MEM_LAT + 1);

  state_e             state;
  op_e                op_q;
  logic [TO_W-1:0]    snp_timer;
  logic [LAT_W-1:0]   mem_timer;
  snp_e               snp_res;
  logic               snp_done;
  logic               accept;
  logic [ADDR_W-1:0]  addr_aligned;

  assign req_ready = (state == StIdle) && !rst;
  assign rsp_valid = (state == StResp);
  assign snp_op    = op_q;
  assign accept    = req_valid && req_ready;

  assign addr_aligned = {req_addr[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};

  // A missing result after the timeout window is treated as NOHIT.
  assign snp_done = snp_result_valid || (snp_timer == TO_W'(SNOOP_TIMEOUT - 1));
  assign snp_res  = snp_result_valid ? norm_snoop(snp_result) : SnpNohit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      op_q      <= OpRead;
      snp_addr  <= '0;
      snp_valid <= 1'b0;
      rsp_snoop <= 2'd0;
      snp_timer <= '0;
      mem_timer <= '0;
    end else begin
      snp_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (req_valid) begin
            op_q      <= op_e'(req_op);
            snp_addr  <= addr_aligned;
            rsp_snoop <= SnpNohit;
            snp_timer <= '0;
            mem_timer <= '0;
            if (op_e'(req_op) == OpWrite) begin
              state <= StMem;
            end else begin
              state     <= StSnoop;
              snp_valid <= 1'b1;
            end
          end
        end
        StSnoop: begin
          if (snp_done) begin
            rsp_snoop <= snp_res;
            if (snp_res == SnpHitm) begin
              state <= StWaitWb;
            end else if (op_q == OpInval) begin
              state <= StResp;
            end else begin
              state <= StMem;
            end
          end else begin
            snp_timer <= snp_timer + TO_W'(1);
          end
        end
        StWaitWb: begin
          if (wb_valid) begin
            state <= (op_q == OpInval) ? StResp : StMem;
          end
        end
        StMem: begin
          if (mem_timer == LAT_W'(MEM_LAT - 1)) begin
            state <= StResp;
          end else begin
            mem_timer <= mem_timer + LAT_W'(1);
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  bus_stat_counter #(.STAT_W(STAT_W)) u_cnt_read (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept && (req_op == OpRead)),
    .count (cnt_read)
  );

  bus_stat_counter #(.STAT_W(STAT_W)) u_cnt_write (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept && (req_op == OpWrite)),
    .count (cnt_write)
  );

  bus_stat_counter #(.STAT_W(STAT_W)) u_cnt_rwim (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept && (req_op == OpRwim)),
    .count (cnt_rwim)
  );

  bus_stat_counter #(.STAT_W(STAT_W)) u_cnt_inval (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept && (req_op == OpInval)),
    .count (cnt_inval)
  );

endmodule

// File: tb/tb_l2_bus_target.sv
// Directed bench for l2_bus_target: latencies, snoop aggregation, back-pressure, reset, saturation.
module tb_l2_bus_target;

  localparam int unsigned STAT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [31:0]       req_addr;
  logic              snp_valid;
  logic [1:0]        snp_op;
  logic [31:0]       snp_addr;
  logic              snp_result_valid;
  logic [1:0]        snp_result;
  logic              wb_valid;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_snoop;
  logic [STAT_W-1:0] cnt_read;
  logic [STAT_W-1:0] cnt_write;
  logic [STAT_W-1:0] cnt_rwim;
  logic [STAT_W-1:0] cnt_inval;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;

  always #5 clk = ~clk;

  l2_bus_target #(
    .ADDR_W       (32),
    .OFFSET_W     (6),
    .MEM_LAT      (4),
    .SNOOP_TIMEOUT(8),
    .STAT_W       (STAT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .snp_valid       (snp_valid),
    .snp_op          (snp_op),
    .snp_addr        (snp_addr),
    .snp_result_valid(snp_result_valid),
    .snp_result      (snp_result),
    .wb_valid        (wb_valid),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_snoop       (rsp_snoop),
    .cnt_read        (cnt_read),
    .cnt_write       (cnt_write),
    .cnt_rwim        (cnt_rwim),
    .cnt_inval       (cnt_inval)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  // Returns with edge_n == 0 just after the accepting edge.
  task automatic accept(input logic [1:0] op, input logic [31:0] addr);
    int guard = 0;
    while (!req_ready && guard < 50) begin
      step();
      guard++;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    step();
    req_valid = 1'b0;
    edge_n    = 0;
  endtask

  task automatic give_result(input logic [1:0] r);
    snp_result_valid = 1'b1;
    snp_result       = r;
    step();
    snp_result_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    while (!rsp_valid && edge_n < 100) step();
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_addr = '0;
    snp_result_valid = 1'b0; snp_result = 2'd0; wb_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) step();
    check("rst_req_ready", req_ready, 0);
    check("rst_snp_valid", snp_valid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_snoop", rsp_snoop, 0);
    check("rst_snp_op", snp_op, 0);
    check("rst_snp_addr", snp_addr, 0);
    check("rst_cnt_read", cnt_read, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", req_ready, 1);

    // READ, NOHIT in the strobe cycle; stray strobes during MEM must be ignored
    accept(2'd0, 32'h1234_5678);
    check("rd_snp_valid", snp_valid, 1);
    check("rd_snp_addr", snp_addr, 32'h1234_5640);
    check("rd_snp_op", snp_op, 0);
    check("rd_busy", req_ready, 0);
    give_result(2'd0);
    check("rd_snp_valid_drop", snp_valid, 0);
    snp_result_valid = 1'b1; snp_result = 2'd2; wb_valid = 1'b1;
    step();
    snp_result_valid = 1'b0; wb_valid = 1'b0;
    wait_rsp();
    check("rd_latency", edge_n, 5);
    check("rd_rsp_snoop", rsp_snoop, 0);
    check("rd_cnt", cnt_read, 1);
    finish_rsp();
    check("rd_idle", req_ready, 1);

    // RWIM, HITM at edge 1, writeback sampled at edge 4
    accept(2'd2, 32'h0000_1000);
    check("rwim_snp_op", snp_op, 2);
    give_result(2'd2);
    step();
    step();
    check("rwim_wait_wb", rsp_valid, 0);
    wb_valid = 1'b1;
    step();
    wb_valid = 1'b0;
    wait_rsp();
    check("rwim_latency", edge_n, 8);
    check("rwim_rsp_snoop", rsp_snoop, 2);
    check("rwim_cnt", cnt_rwim, 1);
    finish_rsp();

    // INVAL, HIT: straight to RESP; rsp_ready already high completes at once
    accept(2'd3, 32'h0000_2040);
    rsp_ready = 1'b1;
    give_result(2'd1);
    wait_rsp();
    check("inval_latency", edge_n, 1);
    check("inval_rsp_snoop", rsp_snoop, 1);
    step();
    rsp_ready = 1'b0;
    check("inval_done", req_ready, 1);
    check("inval_cnt", cnt_inval, 1);

    // INVAL with reserved code behaves as HITM and skips MEM after writeback
    accept(2'd3, 32'h0000_3000);
    give_result(2'd3);
    wb_valid = 1'b1;
    step();
    wb_valid = 1'b0;
    wait_rsp();
    check("inval_rsvd_latency", edge_n, 2);
    check("inval_rsvd_snoop", rsp_snoop, 2);
    finish_rsp();

    // READ with no result: timeout NOHIT at edge 8, response at edge 12
    accept(2'd0, 32'h0000_0040);
    wait_rsp();
    check("to_latency", edge_n, 12);
    check("to_rsp_snoop", rsp_snoop, 0);
    finish_rsp();

    // Two WRITEs; the first held in RESP for 3 cycles
    req_valid = 1'b1; req_op = 2'd1; req_addr = 32'h0000_4000;
    step();
    edge_n = 0;
    check("wr_busy0", req_ready, 0);
    wait_rsp();
    check("wr_latency", edge_n, 4);
    for (int i = 0; i < 3; i++) begin
      check("wr_hold_valid", rsp_valid, 1);
      check("wr_hold_snoop", rsp_snoop, 0);
      check("wr_hold_busy", req_ready, 0);
      step();
    end
    finish_rsp();
    check("wr_ready_again", req_ready, 1);
    step();
    req_valid = 1'b0;
    edge_n = 0;
    wait_rsp();
    check("wr2_latency", edge_n, 4);
    check("wr_cnt", cnt_write, 2);
    finish_rsp();
    check("cnt_read_before_rst", cnt_read, 2);

    // Reset in MEM drops the transaction
    accept(2'd0, 32'h0000_5000);
    give_result(2'd0);
    step();
    rst = 1'b1;
    #1;
    check("midrst_ready", req_ready, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_cnt_read", cnt_read, 0);
    check("midrst_cnt_write", cnt_write, 0);
    step();
    rst = 1'b0;
    #1;
    check("midrst_idle", req_ready, 1);
    for (int i = 0; i < 6; i++) begin
      check("midrst_no_rsp", rsp_valid, 0);
      step();
    end
    accept(2'd0, 32'h0000_6000);
    give_result(2'd0);
    wait_rsp();
    check("postrst_latency", edge_n, 5);
    check("postrst_cnt", cnt_read, 1);
    finish_rsp();

    // 2^STAT_W+1 READs in total saturate the counter
    for (int i = 0; i < (1 << STAT_W); i++) begin
      accept(2'd0, 32'h0000_7000);
      give_result(2'd0);
      wait_rsp();
      finish_rsp();
    end
    check("sat_cnt_read", cnt_read, {STAT_W{1'b1}});
    check("sat_cnt_write", cnt_write, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
